// File: rtl/fetch_prefetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit_pkg
// Shared types and constants for the instruction fetch / prefetch unit.
//   XLEN           : datapath / address width
//   INST_NOP       : value presented on inst_out when no instruction is valid
//   PC_STEP        : fetch address increment (one 32-bit word)
//   fetch_entry_t  : prefetch queue entry {pc, inst}
//   clog2()        : pointer width for a power-of-two FIFO depth
//   sat_add()      : 32-bit saturating add used by the optional perf counters
// ---------------------------------------------------------------------------
package fetch_prefetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. The head entry is visible on 'head' whenever
// 'empty' is low; 'pop' consumes it at the clock edge.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   push, push_data   : write an entry (accepted when not full, or when full
//                       and popping in the same cycle)
//   pop               : consume the head entry (ignored when empty)
//   flush             : discard all entries (wins over push/pop)
//   head              : current head entry
//   full, empty, count: occupancy status
// ---------------------------------------------------------------------------
module sync_fifo
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);

  localparam int PW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours, independent of order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count
  // define which entries are meaningful, so the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_unit
// Instruction fetch stage feeding the IF/ID register. Owns the PC, issues
// in-order word fetches, buffers returned instructions with their PC in a
// DEPTH-entry show-ahead prefetch queue, and flushes on EX redirects.
// Optional feature macro: FETCH_PERF_CNT_EN (adds saturating perf counters).
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   imem_req_valid/ready/addr      : fetch request channel (valid/ready)
//   imem_rsp_valid/data            : in-order response channel (valid only)
//   redirect_valid, redirect_pc    : taken branch / jump from EX (pulse)
//   stall                          : decode cannot accept this cycle
//   inst_valid, inst_out, inst_pc  : queue head toward IF/ID
//   pc_plus4                       : inst_pc + 4
//   perf_fetched/flushed/stall_cyc : (FETCH_PERF_CNT_EN only) counters
// ---------------------------------------------------------------------------
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushed,
  output logic [31:0]     perf_stall_cyc
`endif
);

  localparam int              CW      = clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drain;      // responses still owed to pre-redirect requests
  logic [CW-1:0]   q_count;
  logic [CW-1:0]   tag_count;  // equals the number of requests in flight
  logic            q_full, q_empty, tag_full, tag_empty;
  fetch_entry_t    q_head, q_wr;
  logic [XLEN-1:0] tag_head;
  logic [CW:0]     occ_sum;
  logic            req_fire, rsp_fire, q_push, q_pop;

  assign occ_sum  = {1'b0, q_count} + {1'b0, tag_count};

  // Gated by reset so the request is idle while reset is held.
  assign imem_req_valid = reset && !redirect_valid && !tag_full && (occ_sum < DEPTH_W);
  assign imem_req_addr  = fetch_pc;

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = imem_rsp_valid && !tag_empty;
  assign q_pop    = inst_valid && !stall;
  assign q_push   = rsp_fire && (drain == '0) && !redirect_valid && !q_full;
  assign q_wr     = '{pc: tag_head, inst: imem_rsp_data};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_prefetch_q (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_wr),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // PC tags of in-flight requests. Never flushed: stale tags are popped by
  // their own (dropped) responses while drain counts down.
  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_fire),
    .flush     (1'b0),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      drain    <= '0;
    end else if (redirect_valid) begin
      // No request issues in a redirect cycle, so in-flight after this edge
      // is the current count less any response arriving now.
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      drain    <= tag_count - CW'(rsp_fire);
    end else begin
      if (req_fire)                  fetch_pc <= fetch_pc + PC_STEP;
      if (rsp_fire && drain != '0)   drain    <= drain - CW'(1);
    end
  end

  assign inst_valid = !q_empty;
  assign inst_out   = inst_valid ? q_head.inst : INST_NOP;
  assign inst_pc    = inst_valid ? q_head.pc   : '0;
  assign pc_plus4   = inst_pc + PC_STEP;

`ifdef FETCH_PERF_CNT_EN
  // Discarded by a redirect: queued entries not popped this cycle plus every
  // in-flight request that was not already stale.
  logic [31:0] flushed_now;
  assign flushed_now = 32'(q_count - CW'(q_pop)) + 32'(tag_count - drain);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched   <= '0;
      perf_flushed   <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (req_fire)             perf_fetched   <= sat_add(perf_fetched, 32'd1);
      if (redirect_valid)       perf_flushed   <= sat_add(perf_flushed, flushed_now);
      if (inst_valid && stall)  perf_stall_cyc <= sat_add(perf_stall_cyc, 32'd1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_prefetch_unit
// Self-checking bench for fetch_prefetch_unit (default build). An in-order
// memory model answers requests; a queue-level reference model predicts the
// fetch stream, and every cycle's outputs are compared against it. Directed
// scenarios add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_fetch_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc),
    .pc_plus4       (pc_plus4)
  );

  always #5 clk = ~clk;

  // Memory: in-order outstanding requests (also the in-flight set).
  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          rdy;
  } mreq_t;

  // Reference: instructions delivered and not yet consumed, in order.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  mreq_t       mem_q[$];
  ent_t        mq[$];
  logic [31:0] exp_pc;
  int          cyc;
  int          dut_acc;
  int          n_checks = 0;
  int          n_pass   = 0;

  logic        s_req_valid, s_iv;
  logic [31:0] s_addr, s_pc, s_pc4, s_inst;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
    check({tag, "_req_addr"},  imem_req_addr, 32'h0000_0000);
    check({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
    check({tag, "_inst_out"},  inst_out, 32'd0);
    check({tag, "_inst_pc"},   inst_pc, 32'd0);
    check({tag, "_pc_plus4"},  pc_plus4, 32'd4);
  endtask

  // Assert reset (optionally with garbage responses), then release it just
  // after a rising edge with the model cleared.
  task automatic apply_reset(input bit garbage);
    @(negedge clk);
    reset = 1'b0; imem_req_ready = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_rsp_valid = garbage; imem_rsp_data = 32'h1234_5678;
    #1;
    check_reset_outs("rst_now");
    repeat (2) @(negedge clk);
    #1;
    check_reset_outs("rst_hold");
    mem_q.delete(); mq.delete(); exp_pc = 32'h0; cyc = 0; dut_acc = 0;
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    reset = 1'b1;
  endtask

  // One cycle: drive inputs at negedge, compare against the model, then
  // advance the model by the events of this cycle's rising edge.
  task automatic step(input bit rdy, input bit rspen, input bit stl,
                      input bit redir, input logic [31:0] rpc, input bit bogus);
    bit          rv, e_req, e_iv;
    logic [31:0] rd;
    mreq_t       m;
    @(negedge clk);
    rv = 1'b0;
    rd = $urandom;
    if (rspen && mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
      rv = 1'b1;
      rd = mem_fn(mem_q[0].addr);
    end else if (bogus && mem_q.size() == 0) begin
      rv = 1'b1;
    end
    imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
    stall = stl; redirect_valid = redir; redirect_pc = rpc;
    #1;
    e_req = (mq.size() + mem_q.size() < DEPTH) && !redir;
    e_iv  = (mq.size() > 0);
    check("req_valid",  {31'b0, imem_req_valid}, {31'b0, e_req});
    check("req_addr",   imem_req_addr, exp_pc);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, e_iv});
    if (e_iv) begin
      check("inst_out", inst_out, mq[0].inst);
      check("inst_pc",  inst_pc,  mq[0].pc);
      check("pc_plus4", pc_plus4, mq[0].pc + 32'd4);
    end
    s_req_valid = imem_req_valid; s_addr = imem_req_addr; s_iv = inst_valid;
    s_pc = inst_pc; s_pc4 = pc_plus4; s_inst = inst_out;
    if (imem_req_valid && imem_req_ready) dut_acc++;
    @(posedge clk);
    if (e_iv && !stl) void'(mq.pop_front());
    if (rv && mem_q.size() > 0) begin
      m = mem_q.pop_front();
      if (!m.stale && !redir) mq.push_back('{pc: m.addr, inst: rd});
    end
    if (e_req && rdy) begin
      mem_q.push_back('{addr: exp_pc, stale: 1'b0, rdy: cyc + 1});
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
      mq.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_pc = {rpc[31:2], 2'b00};
    end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and straight-line fetch.
    apply_reset(1'b0);
    step(1, 1, 0, 0, 0, 0);
    check("t1_c0_req_valid", {31'b0, s_req_valid}, 32'd1);
    check("t1_c0_addr", s_addr, 32'h0);
    step(1, 1, 0, 0, 0, 0);
    check("t1_c1_addr", s_addr, 32'h4);
    check("t1_c1_valid", {31'b0, s_iv}, 32'd0);
    step(1, 1, 0, 0, 0, 0);
    check("t1_c2_valid", {31'b0, s_iv}, 32'd1);
    check("t1_c2_pc", s_pc, 32'h0);
    check("t1_c2_pc4", s_pc4, 32'h4);
    check("t1_c2_inst", s_inst, 32'hDEAD_BEEF);
    step(1, 1, 0, 0, 0, 0);
    check("t1_c3_pc", s_pc, 32'h4);
    check("t1_c3_pc4", s_pc4, 32'h8);

    // Stall held: queue fills to DEPTH, head frozen, then drains back to back.
    apply_reset(1'b0);
    repeat (10) step(1, 1, 1, 0, 0, 0);
    check("t2_accepts", dut_acc, 32'd4);
    check("t2_req_valid", {31'b0, s_req_valid}, 32'd0);
    check("t2_frozen_valid", {31'b0, s_iv}, 32'd1);
    check("t2_frozen_pc", s_pc, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0, 0, 0, 0);
      check("t2_drain_valid", {31'b0, s_iv}, 32'd1);
      check("t2_drain_pc", s_pc, 32'(4 * k));
    end

    // Redirect with 3 in flight to an unaligned target.
    apply_reset(1'b0);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h0000_0103, 0);
    check("t3_redir_req_valid", {31'b0, s_req_valid}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    check("t3_req_valid", {31'b0, s_req_valid}, 32'd1);
    check("t3_addr", s_addr, 32'h100);
    check("t3_valid_after", {31'b0, s_iv}, 32'd0);
    for (int k = 0; k < 30; k++) begin
      step(1, 1, 0, 0, 0, 0);
      if (s_iv) break;
    end
    check("t3_first_valid", {31'b0, s_iv}, 32'd1);
    check("t3_first_pc", s_pc, 32'h100);
    check("t3_first_inst", s_inst, 32'h100 ^ 32'hDEAD_BEEF);

    // Redirect coinciding with a response and a pop.
    apply_reset(1'b0);
    repeat (3) step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 32'h0000_0040, 0);
    check("t4_pop_valid", {31'b0, s_iv}, 32'd1);
    check("t4_pop_pc", s_pc, 32'h4);
    step(1, 1, 0, 0, 0, 0);
    check("t4_valid_after", {31'b0, s_iv}, 32'd0);
    check("t4_addr", s_addr, 32'h40);
    for (int k = 0; k < 30; k++) begin
      step(1, 1, 0, 0, 0, 0);
      if (s_iv) break;
    end
    check("t4_first_pc", s_pc, 32'h40);

    // Fetch address wraps at 2^32.
    apply_reset(1'b0);
    step(1, 1, 0, 1, 32'hFFFF_FFFE, 0);
    step(1, 1, 0, 0, 0, 0);
    check("t5_addr_top", s_addr, 32'hFFFF_FFFC);
    step(1, 1, 0, 0, 0, 0);
    check("t5_addr_wrap", s_addr, 32'h0);
    for (int k = 0; k < 30; k++) begin
      if (s_iv) break;
      step(1, 1, 0, 0, 0, 0);
    end
    check("t5_top_pc", s_pc, 32'hFFFF_FFFC);
    check("t5_top_pc4", s_pc4, 32'h0);

    // Reset mid-stream with 2 requests in flight.
    apply_reset(1'b0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    apply_reset(1'b1);
    step(1, 1, 0, 0, 0, 0);
    check("t6_addr", s_addr, 32'h0);
    check("t6_valid", {31'b0, s_iv}, 32'd0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    check("t6_first_pc", s_pc, 32'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
           rpc, $urandom_range(0, 99) < 10);
      if (i == 1500) apply_reset(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
